// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory sequencer: opcodes, state encoding,
// default widths and the memory depth.
package mem_seq_pkg;

  localparam int DEF_AW    = 3;
  localparam int DEF_DW    = 8;
  localparam int DEF_LW    = 4;
  localparam int MEM_WORDS = 8;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WR    = 3'd2,
    ST_CP_RD = 3'd3,
    ST_CP_WR = 3'd4,
    ST_FILL  = 3'd5,
    ST_DONE  = 3'd6,
    ST_VFY   = 3'd7
  } state_e;

endpackage

// File: rtl/mem_seq_addr_gen.sv
// Block address generator: latches source/destination bases and a word count
// on load, then walks an index forward while counting the remaining words down.
// Addresses wrap modulo 2^AW. last is high while the current word is the final one.
module mem_seq_addr_gen
  import mem_seq_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int LW = DEF_LW
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic [LW-1:0] len,
  output logic [AW-1:0] src_next,
  output logic [AW-1:0] dst_cur,
  output logic [AW-1:0] dst_next,
  output logic          last
);

  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] idx_q;
  logic [LW-1:0] remain_q;

  // Base/index/remaining-count registers; load wins over step.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      idx_q    <= '0;
      remain_q <= '0;
    end else if (load) begin
      src_q    <= src_base;
      dst_q    <= dst_base;
      idx_q    <= '0;
      remain_q <= len;
    end else if (step) begin
      idx_q    <= idx_q + AW'(1);
      remain_q <= remain_q - LW'(1);
    end
  end

  assign dst_cur  = dst_q + idx_q;
  assign src_next = src_q + idx_q + AW'(1);
  assign dst_next = dst_q + idx_q + AW'(1);
  assign last     = (remain_q == LW'(1));

endmodule

// File: rtl/mem_sequencer.sv
// Initiator-side sequencer for the 8x8 JK memory: READ, WRITE, COPY, FILL.
// Optional read-back verify after every write: define MEM_SEQ_VERIFY_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a command, cmd_ready high
// RD       | single read, mem_rdata captured into rdata at end of cycle
// WR       | single write strobe
// CP_RD    | copy: read source word into the write-data register
// CP_WR    | copy: write held word to destination
// FILL     | fill: write fill value to current destination word
// VFY      | read back the word just written (verify build only)
// DONE     | one-cycle done pulse, bus idle
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int LW = DEF_LW
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_src,
  input  logic [AW-1:0] cmd_dst,
  input  logic [LW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_wdata,
  output logic [AW-1:0] mem_add,
  output logic          mem_rw,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          err
);

  state_e        state_q, state_nxt;
  logic          accept;
  logic          len_zero;
  logic [LW-1:0] len_sat;
  logic          step;
  logic          last;
  logic [AW-1:0] src_next, dst_cur, dst_next;

  logic [AW-1:0] add_nxt;
  logic          rw_nxt;
  logic [DW-1:0] wdata_nxt;
  logic          done_nxt;
  logic [DW-1:0] rdata_nxt;

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign len_zero  = (cmd_len == '0);
  assign len_sat   = (cmd_len > LW'(MEM_WORDS)) ? LW'(MEM_WORDS) : cmd_len;

  mem_seq_addr_gen #(.AW(AW), .LW(LW)) u_addr_gen (
    .clk      (clk),
    .clear_n  (clear_n),
    .load     (accept),
    .step     (step),
    .src_base (cmd_src),
    .dst_base (cmd_dst),
    .len      (len_sat),
    .src_next (src_next),
    .dst_cur  (dst_cur),
    .dst_next (dst_next),
    .last     (last)
  );

`ifdef MEM_SEQ_VERIFY_EN
  logic [1:0] op_q;

  // Remember the opcode so VFY knows where to resume.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)    op_q <= OP_READ;
    else if (accept) op_q <= cmd_op;
  end

  // Sticky read-back mismatch; mem_wdata still holds the written value in VFY.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)                                      err <= 1'b0;
    else if (state_q == ST_VFY && mem_rdata != mem_wdata) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  // State and registered bus outputs.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= ST_IDLE;
      mem_add   <= '0;
      mem_rw    <= 1'b0;
      mem_wdata <= '0;
      done      <= 1'b0;
      rdata     <= '0;
    end else begin
      state_q   <= state_nxt;
      mem_add   <= add_nxt;
      mem_rw    <= rw_nxt;
      mem_wdata <= wdata_nxt;
      done      <= done_nxt;
      rdata     <= rdata_nxt;
    end
  end

  // Next-state decode; step advances the block index between words.
  always_comb begin
    state_nxt = state_q;
    step      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_READ:  state_nxt = ST_RD;
            OP_WRITE: state_nxt = ST_WR;
            OP_COPY:  state_nxt = len_zero ? ST_DONE : ST_CP_RD;
            default:  state_nxt = len_zero ? ST_DONE : ST_FILL;
          endcase
        end
      end
      ST_RD:    state_nxt = ST_DONE;
      ST_CP_RD: state_nxt = ST_CP_WR;
`ifdef MEM_SEQ_VERIFY_EN
      ST_WR, ST_CP_WR, ST_FILL: state_nxt = ST_VFY;
      ST_VFY: begin
        if (op_q == OP_WRITE || last) begin
          state_nxt = ST_DONE;
        end else begin
          step      = 1'b1;
          state_nxt = (op_q == OP_COPY) ? ST_CP_RD : ST_FILL;
        end
      end
`else
      ST_WR: state_nxt = ST_DONE;
      ST_CP_WR: begin
        if (last) begin
          state_nxt = ST_DONE;
        end else begin
          step      = 1'b1;
          state_nxt = ST_CP_RD;
        end
      end
      ST_FILL: begin
        if (last) begin
          state_nxt = ST_DONE;
        end else begin
          step      = 1'b1;
          state_nxt = ST_FILL;
        end
      end
`endif
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus values for the upcoming state; rw is only ever raised for write states.
  // In COPY the write-data register doubles as the hold register for the read word.
  always_comb begin
    add_nxt   = mem_add;
    rw_nxt    = 1'b0;
    wdata_nxt = mem_wdata;
    done_nxt  = 1'b0;
    rdata_nxt = rdata;
    if (state_q == ST_RD) rdata_nxt = mem_rdata;
    case (state_nxt)
      ST_RD: add_nxt = cmd_src;
      ST_WR: begin
        add_nxt   = cmd_dst;
        wdata_nxt = cmd_wdata;
        rw_nxt    = 1'b1;
      end
      ST_CP_RD: add_nxt = (state_q == ST_IDLE) ? cmd_src : src_next;
      ST_CP_WR: begin
        add_nxt   = dst_cur;
        wdata_nxt = mem_rdata;
        rw_nxt    = 1'b1;
      end
      ST_FILL: begin
        if (state_q == ST_IDLE) begin
          add_nxt   = cmd_dst;
          wdata_nxt = cmd_wdata;
        end else begin
          add_nxt   = dst_next;
        end
        rw_nxt = 1'b1;
      end
      ST_DONE: done_nxt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench for mem_sequencer with a behavioural memory and a
// command-level reference model (memory image, expected write list, latency).
module tb_mem_sequencer;

`ifdef MEM_SEQ_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clear_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_src, cmd_dst;
  logic [3:0] cmd_len;
  logic [7:0] cmd_wdata;
  logic [2:0] mem_add;
  logic       mem_rw;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       done;
  logic [7:0] rdata;
  logic       err;

  logic [7:0]  mem [8];
  logic [7:0]  ref_mem [8];
  logic        force_en = 1'b0;
  logic [10:0] wlog [$];
  logic [10:0] exp_wq [$];
  logic [7:0]  exp_rdata = 8'h00;
  logic        exp_err = 1'b0;
  int          idle_rw = 0;
  int          done_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mem_sequencer dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_len   (cmd_len),
    .cmd_wdata (cmd_wdata),
    .mem_add   (mem_add),
    .mem_rw    (mem_rw),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .done      (done),
    .rdata     (rdata),
    .err       (err)
  );

  // memory array: write on rising edge, combinational read
  always @(posedge clk) if (mem_rw) mem[mem_add] <= mem_wdata;
  assign mem_rdata = force_en ? 8'h00 : mem[mem_add];

  // bus monitor
  always @(negedge clk) begin
    if (mem_rw) begin
      wlog.push_back({mem_add, mem_wdata});
      if (cmd_ready) idle_rw++;
    end
    if (done) done_cnt++;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // command-level reference model
  task automatic model_cmd(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                           input logic [3:0] len, input logic [7:0] wd, output int lat);
    int n;
    logic [2:0] a;
    logic [7:0] v;
    exp_wq.delete();
    n = (len > 4'd8) ? 8 : int'(len);
    case (op)
      2'd0: begin
        exp_rdata = ref_mem[src];
        lat = 2;
      end
      2'd1: begin
        ref_mem[dst] = wd;
        exp_wq.push_back({dst, wd});
        lat = VFY ? 3 : 2;
      end
      2'd2: begin
        for (int i = 0; i < n; i++) begin
          v = ref_mem[3'(int'(src) + i)];
          a = 3'(int'(dst) + i);
          ref_mem[a] = v;
          exp_wq.push_back({a, v});
        end
        lat = (n == 0) ? 1 : (VFY ? 3 * n + 1 : 2 * n + 1);
      end
      default: begin
        for (int i = 0; i < n; i++) begin
          a = 3'(int'(dst) + i);
          ref_mem[a] = wd;
          exp_wq.push_back({a, wd});
        end
        lat = (n == 0) ? 1 : (VFY ? 2 * n + 1 : n + 1);
      end
    endcase
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                         input logic [3:0] len, input logic [7:0] wd);
    int lat_exp;
    int cyc;
    model_cmd(op, src, dst, len, wd, lat_exp);
    @(negedge clk);
    chk_eq("ready_idle", cmd_ready, 1);
    wlog.delete();
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_wdata = wd;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1;
    chk_eq("ready_busy", cmd_ready, 0);
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk_eq("latency", cyc, lat_exp);
    chk_eq("rdata", rdata, exp_rdata);
    chk_eq("err", err, exp_err);
    @(negedge clk);
    chk_eq("done_pulse", done, 0);
    chk_eq("ready_back", cmd_ready, 1);
    chk_eq("wr_count", wlog.size(), exp_wq.size());
    for (int i = 0; i < wlog.size() && i < exp_wq.size(); i++)
      chk_eq("wr_addr_data", wlog[i], exp_wq[i]);
  endtask

  task automatic check_outputs_reset(input string tag);
    chk_eq({tag, "_ready"}, cmd_ready, 1);
    chk_eq({tag, "_bus"}, {mem_add, mem_rw, mem_wdata}, 12'h000);
    chk_eq({tag, "_done"}, done, 0);
    chk_eq({tag, "_rdata"}, rdata, 0);
    chk_eq({tag, "_err"}, err, 0);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 8; i++) chk_eq(tag, mem[i], ref_mem[i]);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clear_n = 1'b0;
    #1;
    check_outputs_reset("rst");
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    exp_rdata = 8'h00;
    exp_err = 1'b0;
  endtask

  task automatic reset_mid_fill();
    int d0;
    int word3;
    word3 = VFY ? 5 : 3;
    for (int i = 0; i < 2; i++) ref_mem[i] = 8'h5A;
    @(negedge clk);
    cmd_op = 2'd3; cmd_src = 3'd0; cmd_dst = 3'd0; cmd_len = 4'd8; cmd_wdata = 8'h5A;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (word3 - 1) @(negedge clk);
    chk_eq("mid_word3", {mem_rw, mem_add}, {1'b1, 3'd2});
    d0 = done_cnt;
    clear_n = 1'b0;
    #1;
    check_outputs_reset("abort");
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    exp_rdata = 8'h00;
    repeat (3) @(negedge clk);
    chk_eq("abort_no_done", done_cnt, d0);
    check_mem("abort_mem");
  endtask

  initial begin
    clear_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'd0; cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_wdata = '0;
    for (int i = 0; i < 8; i++) begin
      mem[i] = 8'h40 + 8'(i);
      ref_mem[i] = 8'h40 + 8'(i);
    end
    #12;
    check_outputs_reset("reset");
    @(negedge clk);
    clear_n = 1'b1;

    // single write then read back
    run_cmd(2'd1, 3'd0, 3'd5, 4'd0, 8'h25);
    run_cmd(2'd0, 3'd5, 3'd0, 4'd0, 8'h00);
    chk_eq("read_5", rdata, 8'h25);

    // wrapping fill, neighbour untouched
    run_cmd(2'd3, 3'd0, 3'd6, 4'd4, 8'hA5);
    run_cmd(2'd0, 3'd2, 3'd0, 4'd0, 8'h00);
    chk_eq("read_2", rdata, 8'h42);

    // copy three words
    run_cmd(2'd1, 3'd0, 3'd0, 4'd0, 8'h11);
    run_cmd(2'd1, 3'd0, 3'd1, 4'd0, 8'h22);
    run_cmd(2'd1, 3'd0, 3'd2, 4'd0, 8'h33);
    run_cmd(2'd2, 3'd0, 3'd4, 4'd3, 8'h00);
    for (int i = 4; i < 7; i++) run_cmd(2'd0, 3'(i), 3'd0, 4'd0, 8'h00);
    chk_eq("read_6", rdata, 8'h33);

    // zero-length and saturated lengths
    run_cmd(2'd3, 3'd0, 3'd3, 4'd0, 8'hEE);
    run_cmd(2'd2, 3'd0, 3'd3, 4'd0, 8'h00);
    run_cmd(2'd2, 3'd1, 3'd0, 4'd12, 8'h00);
    run_cmd(2'd3, 3'd2, 3'd2, 4'd15, 8'h3C);
    check_mem("mem_directed");

    reset_mid_fill();

`ifdef MEM_SEQ_VERIFY_EN
    force_en = 1'b1;
    exp_err = 1'b1;
    run_cmd(2'd1, 3'd0, 3'd3, 4'd0, 8'hFF);
    force_en = 1'b0;
    run_cmd(2'd0, 3'd3, 3'd0, 4'd0, 8'h00);
    chk_eq("err_sticky", err, 1);
    pulse_reset();
    chk_eq("err_cleared", err, 0);
`endif

    for (int k = 0; k < 40; k++) begin
      run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              4'($urandom_range(0, 15)), 8'($urandom));
    end
    check_mem("mem_random");
    pulse_reset();
    chk_eq("idle_rw", idle_rw, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
